simmem_wresp_release_scheduler: RTL

//  Delay scheduler for the write-response message bank. Records each accepted write address (AXI ID +

---
 rtl/simmem_pkg.sv | 14 +
 rtl/simmem_delay_slot.sv | 46 ++++
 rtl/simmem_wresp_release_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// rtl/simmem_pkg.sv - shared widths and slot record for the simulated-memory write-response scheduler
package simmem_pkg;

    localparam int DelayWidth          = 6;
    localparam int IDWidth             = 4;
    localparam int WriteRespSchedSlots = 8;

    typedef struct packed {
        logic                  valid;
        logic [IDWidth-1:0]    id;
        logic [DelayWidth-1:0] counter;
    } wresp_sched_slot_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// rtl/simmem_delay_slot.sv - one tracked write: loads ID and latency, counts down, reports expiry
module simmem_delay_slot
    import simmem_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [IDWidth-1:0]    id_i,
    input  logic [DelayWidth-1:0] delay_i,
    input  logic                  free_i,
    output logic                  valid_o,
    output logic [IDWidth-1:0]    id_o,
    output logic                  expired_o
);

    wresp_sched_slot_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (slot_q.valid && (slot_q.counter != '0)) begin
            slot_d.counter = slot_q.counter - 1'b1;
        end
        if (free_i) begin
            slot_d.valid = 1'b0;
        end
        // The top only loads a free slot, so load never collides with free.
        if (load_i) begin
            slot_d.valid   = 1'b1;
            slot_d.id      = id_i;
            slot_d.counter = delay_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign valid_o   = slot_q.valid;
    assign id_o      = slot_q.id;
    assign expired_o = slot_q.valid && (slot_q.counter == '0);

endmodule

// File: rtl/simmem_wresp_release_scheduler.sv
// rtl/simmem_wresp_release_scheduler.sv - per-ID write-response release scheduler; SIMMEM_SCHED_OCCUPANCY_EN adds occupancy_o
module simmem_wresp_release_scheduler
    import simmem_pkg::*;
#(
    parameter int NumSlots = WriteRespSchedSlots,
    parameter int DelayW   = DelayWidth,
    parameter int IdW      = IDWidth,
    localparam int NumIds  = 2 ** IdW,
    localparam int OccW    = $clog2(NumSlots + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              waddr_valid_i,
    input  logic [IdW-1:0]    waddr_id_i,
    input  logic [DelayW-1:0] waddr_delay_i,
    output logic              waddr_ready_o,
    output logic [NumIds-1:0] release_en_o,
`ifdef SIMMEM_SCHED_OCCUPANCY_EN
    output logic [OccW-1:0]   occupancy_o,
`endif
    input  logic              released_valid_i,
    input  logic [IdW-1:0]    released_id_i
);

    logic [NumSlots-1:0] valid, expired, load, free, head, cand;
    logic [IdW-1:0]      slot_id [NumSlots];
    // older_q[i][j]: slot j was already live when slot i was allocated.
    logic [NumSlots-1:0] older_q [NumSlots];
    logic [NumSlots-1:0] alloc_onehot;
    logic                accept;

    for (genvar s = 0; s < NumSlots; s++) begin : g_slot
        simmem_delay_slot u_slot (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .load_i    (load[s]),
            .id_i      (waddr_id_i),
            .delay_i   (waddr_delay_i),
            .free_i    (free[s]),
            .valid_o   (valid[s]),
            .id_o      (slot_id[s]),
            .expired_o (expired[s])
        );
    end

    assign waddr_ready_o = ~&valid;
    assign accept        = waddr_valid_i && waddr_ready_o;

    always_comb begin
        alloc_onehot = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_onehot    = '0;
                alloc_onehot[i] = 1'b1;
            end
        end
    end

    assign load = accept ? alloc_onehot : '0;

    // A slot heads its ID queue when no live same-ID slot predates it.
    always_comb begin
        head = '0;
        for (int s = 0; s < NumSlots; s++) begin
            head[s] = valid[s];
            for (int j = 0; j < NumSlots; j++) begin
                if (valid[j] && older_q[s][j] && (slot_id[j] == slot_id[s])) begin
                    head[s] = 1'b0;
                end
            end
        end
    end

    assign cand = head & expired;

    always_comb begin
        release_en_o = '0;
        free         = '0;
        for (int s = 0; s < NumSlots; s++) begin
            if (cand[s]) begin
                release_en_o[slot_id[s]] = 1'b1;
            end
            free[s] = released_valid_i && cand[s] && (slot_id[s] == released_id_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                for (int j = 0; j < NumSlots; j++) begin
                    if (load[i]) begin
                        older_q[i][j] <= valid[j];
                    end else if (load[j]) begin
                        older_q[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef SIMMEM_SCHED_OCCUPANCY_EN
    always_comb begin
        occupancy_o = '0;
        for (int s = 0; s < NumSlots; s++) begin
            occupancy_o = occupancy_o + OccW'(valid[s]);
        end
    end
`endif

    illegal_release_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        released_valid_i |-> release_en_o[released_id_i])
        else $warning("wresp scheduler: release of ID %0d ignored, not enabled", released_id_i);

endmodule
